// File: rtl/mb_addsub_seq_if.sv
// mb_addsub_seq_if: request/response bundle for the multi-byte add/sub sequencer.
//   master: drives start/op_sub/opa/opb, observes busy/done/result/flags.
//   slave : the sequencer side.
interface mb_addsub_seq_if #(parameter int NBYTES = 4);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, op_sub, opa, opb,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op_sub, opa, opb,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/mb_addsub_seq.sv
// mb_addsub_seq: feeds an external 8-bit combinational add/sub adder one limb
// per cycle and chains its carry to build an NBYTES*8-bit add or subtract.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : start/op_sub/opa/opb in; busy/done/result/flags out
//   adder_a/b/cin (out)   : limb operands to the adder (zero outside RUN)
//   adder_sum/cout (in)   : adder result for the current limb
module mb_addsub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mb_addsub_seq_if.slave      bus,
  output logic [7:0]          adder_a,
  output logic [7:0]          adder_b,
  output logic                adder_cin,
  input  logic [7:0]          adder_sum,
  input  logic                adder_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  opa_r, opb_r, result_r, new_res;
  logic          sub_r, carry;
  logic [IW-1:0] idx;
  logic          cout_r, ovf_r, zero_r;
  logic [7:0]    a_byte, b_byte, beff;
  logic          last;

  assign last = (idx == IW'(NBYTES - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (last)      state_nxt = S_DONE;
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // limb select and the result as it will look after this cycle's capture
  always_comb begin
    a_byte  = '0;
    b_byte  = '0;
    new_res = result_r;
    for (int i = 0; i < NBYTES; i++)
      if (idx == IW'(i)) begin
        a_byte               = opa_r[i*8 +: 8];
        b_byte               = opb_r[i*8 +: 8];
        new_res[i*8 +: 8]    = adder_sum;
      end
  end

  assign beff = sub_r ? ~b_byte : b_byte;

  // outputs: the adder inverts B whenever Cin=1, so B is pre-inverted by the
  // carry to cancel that; the adder then computes A + beff + carry per limb.
  always_comb begin
    bus.busy  = (state == S_RUN);
    bus.done  = (state == S_DONE);
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state == S_RUN) begin
      adder_a   = a_byte;
      adder_b   = beff ^ {8{carry}};
      adder_cin = carry;
    end
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opa_r    <= '0;
      opb_r    <= '0;
      sub_r    <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      opa_r <= bus.opa;
      opb_r <= bus.opb;
      sub_r <= bus.op_sub;
      idx   <= '0;
      carry <= bus.op_sub;  // +1 of the two's-complement negate
    end else if (state == S_RUN) begin
      result_r <= new_res;
      carry    <= adder_cout;
      if (last) begin
        cout_r <= adder_cout;
        // same-sign operands (after negation for sub) producing opposite-sign result
        ovf_r  <= (opa_r[W-1] == (sub_r ^ opb_r[W-1])) && (adder_sum[7] != opa_r[W-1]);
        zero_r <= (new_res == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end

  assign bus.result    = result_r;
  assign bus.carry_out = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_mb_addsub_seq.sv
// Bench for mb_addsub_seq: models the external 8-bit add/sub adder
// (B inverted when Cin=1) and checks results against W-bit arithmetic.
module tb_mb_addsub_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adder_a, adder_b, adder_sum;
  logic       adder_cin, adder_cout;
  int         checks = 0;
  int         errors = 0;

  mb_addsub_seq_if #(.NBYTES(NBYTES)) bus ();

  mb_addsub_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  // external ripple adder: Sum = A + (B ^ {8{Cin}}) + Cin
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b ^ {8{adder_cin}}} + {8'd0, adder_cin};

  always #5 clk = ~clk;

  // reference: plain W-bit two's-complement arithmetic
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] res, output logic co, output logic ov, output logic z);
    logic [W:0] full;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, b};
    res = full[W-1:0];
    co  = full[W];
    ov  = sub ? (a[W-1] != b[W-1]) && (res[W-1] != a[W-1])
              : (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    z   = (res == '0);
  endtask

  // one operation from IDLE; returns observed outputs at done
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] res, output logic co, output logic ov, output logic z,
                       output int busy_cnt, output int done_cnt, output logic tmo);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.opa = a; bus.opb = b; bus.op_sub = sub;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0; n = 0;
    while (!bus.done && n < 50) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk); n++;
    end
    tmo = !bus.done;
    res = bus.result; co = bus.carry_out; ov = bus.overflow; z = bus.zero;
    done_cnt = 0;
    while (bus.done && done_cnt < 5) begin
      done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.carry_out, bus.overflow, bus.zero} !== 5'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b co=%b ov=%b z=%b result=%h, want all 0",
               bus.busy, bus.done, bus.carry_out, bus.overflow, bus.zero, bus.result);
    end
    checks++;
    if ({adder_a, adder_b, adder_cin} !== 17'b0) begin
      errors++;
      $display("FAIL reset_adder_drive: a=%h b=%h cin=%b, want 0", adder_a, adder_b, adder_cin);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    logic [W-1:0] res; logic co, ov, z, tmo; int bc, dc;
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, res, co, ov, z, bc, dc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL add_basic_timeout: done never seen"); end
    checks++;
    if ({res, co, ov, z} !== {32'h0000_0100, 3'b000}) begin
      errors++;
      $display("FAIL add_basic: result=%h co=%b ov=%b z=%b, want 00000100 0 0 0", res, co, ov, z);
    end
    checks++;
    if (bc != NBYTES) begin errors++; $display("FAIL busy_cycles: got %0d, want %0d", bc, NBYTES); end
    checks++;
    if (dc != 1) begin errors++; $display("FAIL done_width: got %0d, want 1", dc); end
  endtask

  task automatic test_sub_zero();
    logic [W-1:0] res; logic co, ov, z, tmo; int bc, dc;
    do_op(32'h5, 32'h5, 1'b1, res, co, ov, z, bc, dc, tmo);
    checks++;
    if (tmo || {res, co, ov, z} !== {32'h0, 3'b101}) begin
      errors++;
      $display("FAIL sub_zero: tmo=%b result=%h co=%b ov=%b z=%b, want 00000000 1 0 1", tmo, res, co, ov, z);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] res; logic co, ov, z, tmo; int bc, dc;
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, res, co, ov, z, bc, dc, tmo);
    checks++;
    if (tmo || {res, co, ov, z} !== {32'h8000_0000, 3'b010}) begin
      errors++;
      $display("FAIL add_ovf: tmo=%b result=%h co=%b ov=%b z=%b, want 80000000 0 1 0", tmo, res, co, ov, z);
    end
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, co, ov, z, bc, dc, tmo);
    checks++;
    if (tmo || {res, co, ov, z} !== {32'hFFFF_FFFE, 3'b100}) begin
      errors++;
      $display("FAIL add_carry: tmo=%b result=%h co=%b ov=%b z=%b, want fffffffe 1 0 0", tmo, res, co, ov, z);
    end
  endtask

  // 0 - 1: limb 0 sends B=0x01 with Cin=1; the carry chain is 0 afterwards, so
  // upper limbs send ~0x00 = 0xFF uninverted with Cin=0.
  task automatic test_adder_drive();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.opa = '0; bus.opb = 32'h1; bus.op_sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (adder_a !== 8'h00 || adder_b !== 8'h01 || adder_cin !== 1'b1) begin
      errors++;
      $display("FAIL drive_limb0: a=%h b=%h cin=%b, want 00 01 1", adder_a, adder_b, adder_cin);
    end
    for (int i = 1; i < NBYTES; i++) begin
      @(negedge clk);
      checks++;
      if (adder_b !== 8'hFF || adder_cin !== 1'b0) begin
        errors++;
        $display("FAIL drive_limb%0d: b=%h cin=%b, want ff 0", i, adder_b, adder_cin);
      end
    end
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.done || bus.result !== 32'hFFFF_FFFF || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: done=%b result=%h co=%b ov=%b, want 1 ffffffff 0 0",
               bus.done, bus.result, bus.carry_out, bus.overflow);
    end
    checks++;
    if ({adder_a, adder_b, adder_cin} !== 17'b0) begin
      errors++;
      $display("FAIL drive_done_idle: a=%h b=%h cin=%b, want 0", adder_a, adder_b, adder_cin);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_and_reset();
    logic [W-1:0] res; logic co, ov, z, tmo; int bc, dc, n, extra;
    @(negedge clk);
    bus.start = 1'b1; bus.opa = 32'h1; bus.opb = 32'h2; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);  // RUN cycle 2
    bus.start = 1'b1; bus.opa = 32'h5555_5555; bus.opb = 32'h1234_5678; bus.op_sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bus.done || bus.result !== 32'h3) begin
      errors++;
      $display("FAIL start_ignored: done=%b result=%h, want 1 00000003", bus.done, bus.result);
    end
    extra = 0;
    for (int i = 0; i < 2*NBYTES + 4; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL no_second_done: saw %0d, want 0", extra); end

    // reset in the middle of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.opa = 32'hDEAD_BEEF; bus.opb = 32'h0101_0101; bus.op_sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.carry_out, bus.overflow, bus.zero} !== 5'b0 || bus.result !== '0 ||
        {adder_a, adder_b, adder_cin} !== 17'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b result=%h a=%h b=%h cin=%b, want all 0",
               bus.busy, bus.done, bus.result, adder_a, adder_b, adder_cin);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 2*NBYTES + 4; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL abort_no_done: %0d busy/done cycles, want 0", extra); end
    do_op(32'h3, 32'h4, 1'b0, res, co, ov, z, bc, dc, tmo);
    checks++;
    if (tmo || res !== 32'h7 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_add: tmo=%b result=%h z=%b, want 00000007 0", tmo, res, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, er; logic s, eco, eov, ez;
    int n, gap;
    a = 32'h8000_0000; b = 32'h1; s = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.opa = a; bus.opb = b; bus.op_sub = s;
    for (int k = 0; k < 200; k++) begin
      model(a, b, s, er, eco, eov, ez);
      n = 0;
      @(negedge clk); n++;
      while (!bus.done && n < 50) begin @(negedge clk); n++; end
      gap = n;
      checks++;
      if (!bus.done || bus.result !== er || bus.carry_out !== eco || bus.overflow !== eov || bus.zero !== ez) begin
        errors++;
        $display("FAIL b2b[%0d] %h %s %h: done=%b result=%h co=%b ov=%b z=%b, want %h %b %b %b",
                 k, a, s ? "-" : "+", b, bus.done, bus.result, bus.carry_out, bus.overflow, bus.zero,
                 er, eco, eov, ez);
      end
      if (k == 0) begin
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL b2b_min_minus_one_ovf: ov=%b, want 1", bus.overflow); end
      end else begin
        checks++;
        if (gap != NBYTES + 2) begin errors++; $display("FAIL b2b_interval[%0d]: %0d cycles, want %0d", k, gap, NBYTES + 2); end
      end
      if (!bus.done) begin
        $display("FAIL b2b_stall: done not seen, aborting sequence");
        errors++;
        break;
      end
      // next operands: accepted two edges later (DONE -> IDLE -> accept)
      a = $urandom; b = (k % 10 == 3) ? a : $urandom; s = 1'($urandom_range(0, 1));
      bus.opa = a; bus.opb = b; bus.op_sub = s;
    end
    bus.start = 1'b0;
    repeat (NBYTES + 4) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.opa = '0; bus.opb = '0;
    test_reset();
    test_add_basic();
    test_sub_zero();
    test_overflow();
    test_adder_drive();
    test_ignore_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
